// File: rtl/fc.sv
// Flow controller: registers the five FIFOs' status flags onto buses and gates writes
// into destination FIFOs 1..4 with a per-channel RUN/PAUSE hysteresis state.
module fc (
    input  logic       clk,
    input  logic       reset,
    input  logic       aff0,
    input  logic       aff1,
    input  logic       aff2,
    input  logic       aff3,
    input  logic       aff4,
    input  logic       ff0,
    input  logic       ff1,
    input  logic       ff2,
    input  logic       ff3,
    input  logic       ff4,
    input  logic       aef0,
    input  logic       aef1,
    input  logic       aef2,
    input  logic       aef3,
    input  logic       aef4,
    input  logic       ef0,
    input  logic       ef1,
    input  logic       ef2,
    input  logic       ef3,
    input  logic       ef4,
    input  logic [3:0] continuar,
    output logic [4:0] almost_full,
    output logic [4:0] full,
    output logic [4:0] almost_empty,
    output logic [4:0] empty,
    output logic [3:0] cf
);

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } chan_state_t;

    logic [4:0] aff_bus;
    logic [4:0] ff_bus;
    logic [4:0] aef_bus;
    logic [4:0] ef_bus;

    assign aff_bus = {aff4, aff3, aff2, aff1, aff0};
    assign ff_bus  = {ff4, ff3, ff2, ff1, ff0};
    assign aef_bus = {aef4, aef3, aef2, aef1, aef0};
    assign ef_bus  = {ef4, ef3, ef2, ef1, ef0};

    logic [4:0] almost_full_reg;
    logic [4:0] full_reg;
    logic [4:0] almost_empty_reg;
    logic [4:0] empty_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full_reg  <= 5'b00000;
            full_reg         <= 5'b00000;
            almost_empty_reg <= 5'b00000;
            empty_reg        <= 5'b11111;
        end else begin
            almost_full_reg  <= aff_bus;
            full_reg         <= ff_bus;
            almost_empty_reg <= aef_bus;
            empty_reg        <= ef_bus;
        end
    end

    assign almost_full  = almost_full_reg;
    assign full         = full_reg;
    assign almost_empty = almost_empty_reg;
    assign empty        = empty_reg;

    chan_state_t [3:0] state_reg;
    chan_state_t [3:0] state_next;
    logic        [3:0] cf_reg;
    logic        [3:0] cf_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic full_side;
            logic empty_side;

            // Channel gi feeds destination FIFO gi+1; the full side wins on contradiction.
            assign full_side  = aff_bus[gi+1] | ff_bus[gi+1];
            assign empty_side = aef_bus[gi+1] | ef_bus[gi+1];

            always_comb begin
                state_next[gi] = state_reg[gi];
                if (full_side) begin
                    state_next[gi] = PAUSE;
                end else if (empty_side) begin
                    state_next[gi] = RUN;
                end
            end

            // continuar only masks the enable; it never touches the channel state.
            assign cf_next[gi] = continuar[gi] & (state_next[gi] == RUN) & ~ef_bus[0];

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg[gi] <= RUN;
                    cf_reg[gi]    <= 1'b0;
                end else begin
                    state_reg[gi] <= state_next[gi];
                    cf_reg[gi]    <= cf_next[gi];
                end
            end
        end
    endgenerate

    assign cf = cf_reg;

endmodule

// File: tb/tb_fc.sv
// Directed and random scoreboard bench for fc; expectations come from a small behavioural model.
module tb_fc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] aff, ff, aef, ef;
    logic [3:0] continuar;
    logic [4:0] almost_full, full, almost_empty, empty;
    logic [3:0] cf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] af;
        logic [4:0] f;
        logic [4:0] ae;
        logic [4:0] e;
        logic [3:0] cf;
    } exp_t;

    exp_t exp_q[$];
    logic [3:0] model_pause;

    always #5 clk = ~clk;

    fc dut (
        .clk          (clk),
        .reset        (reset),
        .aff0         (aff[0]),
        .aff1         (aff[1]),
        .aff2         (aff[2]),
        .aff3         (aff[3]),
        .aff4         (aff[4]),
        .ff0          (ff[0]),
        .ff1          (ff[1]),
        .ff2          (ff[2]),
        .ff3          (ff[3]),
        .ff4          (ff[4]),
        .aef0         (aef[0]),
        .aef1         (aef[1]),
        .aef2         (aef[2]),
        .aef3         (aef[3]),
        .aef4         (aef[4]),
        .ef0          (ef[0]),
        .ef1          (ef[1]),
        .ef2          (ef[2]),
        .ef3          (ef[3]),
        .ef4          (ef[4]),
        .continuar    (continuar),
        .almost_full  (almost_full),
        .full         (full),
        .almost_empty (almost_empty),
        .empty        (empty),
        .cf           (cf)
    );

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One transaction: drive at negedge, predict, sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic [4:0] a_aff, input logic [4:0] a_ff,
                        input logic [4:0] a_aef, input logic [4:0] a_ef, input logic [3:0] a_cont);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = rst; aff = a_aff; ff = a_ff; aef = a_aef; ef = a_ef; continuar = a_cont;
        if (rst) begin
            model_pause = 4'b0000;
            e.af = 5'b00000; e.f = 5'b00000; e.ae = 5'b00000; e.e = 5'b11111; e.cf = 4'b0000;
        end else begin
            e.af = a_aff; e.f = a_ff; e.ae = a_aef; e.e = a_ef;
            for (int i = 0; i < 4; i++) begin
                if (a_aff[i+1] || a_ff[i+1])       model_pause[i] = 1'b1;
                else if (a_aef[i+1] || a_ef[i+1])  model_pause[i] = 1'b0;
                e.cf[i] = a_cont[i] && !model_pause[i] && !a_ef[0];
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = exp_q.pop_front();
            check("almost_full", almost_full, got.af);
            check("full", full, got.f);
            check("almost_empty", almost_empty, got.ae);
            check("empty", empty, got.e);
            check("cf", {1'b0, cf}, {1'b0, got.cf});
        end
        $display("step rst=%b aff=%b ff=%b aef=%b ef=%b cont=%b -> af=%b f=%b ae=%b e=%b cf=%b",
                 rst, a_aff, a_ff, a_aef, a_ef, a_cont, almost_full, full, almost_empty, empty, cf);
    endtask

    initial begin
        reset = 1'b1; aff = '0; ff = '0; aef = '0; ef = '0; continuar = '0;
        model_pause = 4'b0000;

        // Reset with noisy flags
        step(1, 5'b10101, 5'b01010, 5'b11111, 5'b00000, 4'b1111);
        step(1, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 4'b1111);
        check("reset_empty", empty, 5'b11111);
        check("reset_cf", {1'b0, cf}, 5'b00000);

        // All empty: ef0 gates every channel
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 4'b1111);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 4'b1111);
        check("ef0_gate_cf", {1'b0, cf}, 5'b00000);

        // All almost empty
        step(0, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 4'b1111);
        check("aef_cf", {1'b0, cf}, 5'b01111);
        check("aef_empty", empty, 5'b00000);

        // All almost full, then hysteresis hold
        step(0, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
        check("aff_cf", {1'b0, cf}, 5'b00000);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
        check("hyst_cf", {1'b0, cf}, 5'b00000);

        // Source aff0 plus destination full
        step(0, 5'b00001, 5'b11110, 5'b00000, 5'b00000, 4'b0001);
        check("full_bus", full, 5'b11110);
        check("full_cf", {1'b0, cf}, 5'b00000);

        // Recover everything, then pause channel 2 and resume it
        step(0, 5'b00000, 5'b00000, 5'b11110, 5'b00000, 4'b1111);
        step(0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
        check("ch2_paused", {1'b0, cf}, 5'b01011);
        step(0, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 4'b1111);
        check("ch2_resume", {1'b0, cf}, 5'b01111);

        // Contradictory flags: full side wins
        step(0, 5'b00010, 5'b00000, 5'b00010, 5'b00010, 4'b1111);
        check("contradict", {1'b0, cf}, 5'b01110);
        step(0, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 4'b1111);

        // continuar masks without changing state
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'b0000);
        check("cont_mask", {1'b0, cf}, 5'b00000);
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
        check("cont_restore", {1'b0, cf}, 5'b01111);

        // Source FIFO almost-full/full/almost-empty do not gate
        step(0, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 4'b1111);
        check("src_no_gate", {1'b0, cf}, 5'b01111);

        // Pause some channels, then reset mid-operation
        step(0, 5'b00110, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
        step(1, 5'b10101, 5'b11011, 5'b01110, 5'b00100, 4'b1111);
        check("midreset_cf", {1'b0, cf}, 5'b00000);
        check("midreset_empty", empty, 5'b11111);
        // First post-reset edge computes normally (reset cleared PAUSE)
        step(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'b1111);
        check("post_reset_cf", {1'b0, cf}, 5'b01111);

        // Random traffic, biased so states actually toggle
        for (int n = 0; n < 60; n++) begin
            logic [4:0] r_aff, r_ff, r_aef, r_ef;
            r_aff = 5'($urandom) & 5'($urandom);
            r_ff  = 5'($urandom) & 5'($urandom) & 5'($urandom);
            r_aef = 5'($urandom);
            r_ef  = 5'($urandom) & 5'($urandom);
            step(($urandom_range(0, 19) == 0), r_aff, r_ff, r_aef, r_ef, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
